icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_line_ram.sv | 24 ++
 rtl/icache.sv | 109 ++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - icache geometry constants, FSM encoding and line word select helper
package icache_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int TAG_W  = 22;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 4;
  localparam int WSEL_W = 2;
  localparam int LINES  = 64;
  localparam int WORDS  = 4;
  localparam int LINE_W = WORDS * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [WSEL_W-1:0] sel);
    return line[{sel, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// rtl/icache_line_ram.sv - 64 x 128-bit line storage, async read, word-granular write
module icache_line_ram
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WSEL_W-1:0] wr_word_i,
  input  logic [WORD_W-1:0] wr_data_i
);

  logic [LINE_W-1:0] mem_q [LINES];

  assign rd_line_o = mem_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_idx_i][{wr_word_i, 5'b00000} +: WORD_W] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped 1 KiB instruction cache, zero-latency hit, 4-word refill
module icache
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [WORD_W-1:0] data_o,
  output logic              stallreq_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [WORD_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_word;

  assign req_tag  = addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx  = addr_i[OFF_W +: IDX_W];
  assign req_word = addr_i[2 +: WSEL_W];

  state_e            state_q;
  logic [WSEL_W-1:0] cnt_q;
  logic [TAG_W-1:0]  tag_lat_q;
  logic [IDX_W-1:0]  idx_lat_q;
  logic [LINES-1:0]  valid_q;
  logic              mem_re_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [TAG_W-1:0]  tag_q [LINES];

  logic [LINE_W-1:0] rd_line;
  logic              hit;
  logic              miss;
  logic              fill_we;

  assign hit     = ce_i && (state_q == ST_IDLE) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss    = ce_i && !hit;
  assign fill_we = (state_q == ST_FILL) && mem_ack_i;

  assign data_o     = hit ? line_word(rd_line, req_word) : '0;
  assign stallreq_o = (state_q != ST_IDLE) || miss;
  assign mem_re_o   = mem_re_q;
  assign mem_addr_o = mem_addr_q;

  icache_line_ram u_line_ram (
    .clk       (clk),
    .rd_idx_i  (req_idx),
    .rd_line_o (rd_line),
    .we_i      (fill_we),
    .wr_idx_i  (idx_lat_q),
    .wr_word_i (cnt_q),
    .wr_data_i (mem_data_i)
  );

  // Refill request and address are registered so they hold steady through wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tag_lat_q  <= '0;
      idx_lat_q  <= '0;
      valid_q    <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss) begin
            state_q          <= ST_FILL;
            tag_lat_q        <= req_tag;
            idx_lat_q        <= req_idx;
            cnt_q            <= '0;
            valid_q[req_idx] <= 1'b0;
            mem_re_q         <= 1'b1;
            mem_addr_q       <= {req_tag, req_idx, 2'b00, 2'b00};
          end
        end
        ST_FILL: begin
          if (mem_ack_i) begin
            if (cnt_q == 2'd3) begin
              state_q    <= ST_COMMIT;
              mem_re_q   <= 1'b0;
              mem_addr_q <= '0;
            end else begin
              cnt_q      <= cnt_q + 2'd1;
              mem_addr_q <= {tag_lat_q, idx_lat_q, cnt_q + 2'd1, 2'b00};
            end
          end
        end
        ST_COMMIT: begin
          valid_q[idx_lat_q] <= 1'b1;
          cnt_q              <= '0;
          state_q            <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_COMMIT) begin
      tag_q[idx_lat_q] <= tag_lat_q;
    end
  end

endmodule
